// File: rtl/wb_arbiter_if.sv
// Functional-unit result ports and the single writeback broadcast
// shared between the units, the arbiter and its consumers.
interface wb_arbiter_if #(
    parameter int NUM_FU = 4
);
    logic [NUM_FU-1:0]    fu_valid;
    logic [NUM_FU*32-1:0] fu_data;
    logic [NUM_FU*7-1:0]  fu_rd;
    logic [NUM_FU*3-1:0]  fu_rob_idx;
    logic [NUM_FU-1:0]    fu_ready;
    logic                 mispredict;
    logic [7:0]           flush_mask;
    logic                 WB_valid;
    logic [31:0]          WB_data;
    logic [6:0]           WB_rd;
    logic [2:0]           WB_rob_idx;
    logic                 WB_rf_en;

    modport master (
        output fu_valid, fu_data, fu_rd, fu_rob_idx,
        output mispredict, flush_mask,
        input  fu_ready,
        input  WB_valid, WB_data, WB_rd, WB_rob_idx, WB_rf_en
    );

    modport slave (
        input  fu_valid, fu_data, fu_rd, fu_rob_idx,
        input  mispredict, flush_mask,
        output fu_ready,
        output WB_valid, WB_data, WB_rd, WB_rob_idx, WB_rf_en
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one result buffer per functional unit, round-robin
// selection onto a registered single-port writeback bus with ROB flush.
module wb_arbiter #(
    parameter int NUM_FU = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] bv_q, bv_d;
    logic [31:0]       bd_q   [NUM_FU];
    logic [31:0]       bd_d   [NUM_FU];
    logic [6:0]        brd_q  [NUM_FU];
    logic [6:0]        brd_d  [NUM_FU];
    logic [2:0]        brob_q [NUM_FU];
    logic [2:0]        brob_d [NUM_FU];
    logic [PW-1:0]     rr_q, rr_d;

    logic              wbv_q, wbv_d;
    logic              wbrf_q, wbrf_d;
    logic [31:0]       wbd_q, wbd_d;
    logic [6:0]        wbrd_q, wbrd_d;
    logic [2:0]        wbrob_q, wbrob_d;

    logic [NUM_FU-1:0] kill_buf;
    logic [NUM_FU-1:0] kill_in;
    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] gnt;
    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] fire;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     pidx;
    logic              found;

    always_comb begin
        kill_buf = '0;
        kill_in  = '0;
        elig     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            kill_buf[i] = bus.mispredict
                        && bus.flush_mask[brob_q[i]];
            kill_in[i]  = bus.mispredict
                        && bus.flush_mask[bus.fu_rob_idx[3*i +: 3]];
            elig[i]     = bv_q[i] && !kill_buf[i];
        end
    end

    // First eligible port at or after rr_q, wrapping.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        pidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            pidx = PW'((int'(rr_q) + k) % NUM_FU);
            if (!found && elig[pidx]) begin
                found     = 1'b1;
                gnt[pidx] = 1'b1;
                gidx      = pidx;
            end
        end
    end

    assign ready        = ~bv_q | gnt;
    assign fire         = bus.fu_valid & ready;
    assign bus.fu_ready = ready;

    always_comb begin
        bv_d   = bv_q;
        bd_d   = bd_q;
        brd_d  = brd_q;
        brob_d = brob_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fire[i]) begin
                // A squashed incoming result leaves the slot empty.
                bv_d[i] = !kill_in[i];
                if (!kill_in[i]) begin
                    bd_d[i]   = bus.fu_data[32*i +: 32];
                    brd_d[i]  = bus.fu_rd[7*i +: 7];
                    brob_d[i] = bus.fu_rob_idx[3*i +: 3];
                end
            end else if (gnt[i] || kill_buf[i]) begin
                bv_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        wbv_d   = found;
        wbrf_d  = found && (brd_q[gidx] != '0);
        wbd_d   = found ? bd_q[gidx]   : wbd_q;
        wbrd_d  = found ? brd_q[gidx]  : wbrd_q;
        wbrob_d = found ? brob_q[gidx] : wbrob_q;
        rr_d    = rr_q;
        if (found) begin
            rr_d = (gidx == PW'(NUM_FU - 1))
                 ? '0 : gidx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bv_q    <= '0;
            rr_q    <= '0;
            wbv_q   <= 1'b0;
            wbrf_q  <= 1'b0;
            wbd_q   <= '0;
            wbrd_q  <= '0;
            wbrob_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                bd_q[i]   <= '0;
                brd_q[i]  <= '0;
                brob_q[i] <= '0;
            end
        end else begin
            bv_q    <= bv_d;
            rr_q    <= rr_d;
            wbv_q   <= wbv_d;
            wbrf_q  <= wbrf_d;
            wbd_q   <= wbd_d;
            wbrd_q  <= wbrd_d;
            wbrob_q <= wbrob_d;
            for (int i = 0; i < NUM_FU; i++) begin
                bd_q[i]   <= bd_d[i];
                brd_q[i]  <= brd_d[i];
                brob_q[i] <= brob_d[i];
            end
        end
    end

    assign bus.WB_valid   = wbv_q;
    assign bus.WB_rf_en   = wbrf_q;
    assign bus.WB_data    = wbd_q;
    assign bus.WB_rd      = wbrd_q;
    assign bus.WB_rob_idx = wbrob_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations
// plus a per-cycle comparison against a slot/round-robin model.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_FU(4)) bus ();

    wb_arbiter #(.NUM_FU(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [6:0]  rd;
        logic [2:0]  rob;
    } ent_t;

    ent_t        mb [4] = '{default: '0};
    int          m_ptr = 0;
    logic        e_v = 1'b0;
    logic        e_rf = 1'b0;
    logic [31:0] e_d = '0;
    logic [6:0]  e_rd = '0;
    logic [2:0]  e_rob = '0;

    function automatic logic killed(input logic [2:0] r);
        return bus.mispredict && bus.flush_mask[r];
    endfunction

    function automatic int m_win();
        for (int k = 0; k < 4; k++) begin
            int p = (m_ptr + k) % 4;
            if (mb[p].v && !killed(mb[p].rob)) return p;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        int w;
        w = m_win();
        for (int i = 0; i < 4; i++)
            r[i] = !mb[i].v || (w == i);
        return r;
    endfunction

    always @(posedge clk) begin
        ent_t       nb [4];
        int         w;
        logic [3:0] rdy;
        logic [2:0] irob;
        if (rst) begin
            mb    <= '{default: '0};
            m_ptr <= 0;
            e_v   <= 1'b0;
            e_rf  <= 1'b0;
            e_d   <= '0;
            e_rd  <= '0;
            e_rob <= '0;
        end else begin
            nb  = mb;
            w   = m_win();
            rdy = m_ready();
            if (w >= 0) begin
                e_v   <= 1'b1;
                e_rf  <= (mb[w].rd != 0);
                e_d   <= mb[w].d;
                e_rd  <= mb[w].rd;
                e_rob <= mb[w].rob;
                m_ptr <= (w + 1) % 4;
            end else begin
                e_v  <= 1'b0;
                e_rf <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                irob = bus.fu_rob_idx[3*i +: 3];
                if (bus.fu_valid[i] && rdy[i]) begin
                    if (killed(irob)) nb[i] = '0;
                    else nb[i] = '{v: 1'b1,
                                   d: bus.fu_data[32*i +: 32],
                                   rd: bus.fu_rd[7*i +: 7],
                                   rob: irob};
                end else if (i == w || killed(mb[i].rob)) begin
                    nb[i].v = 1'b0;
                end
            end
            mb <= nb;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_fu_ready", 32'(bus.fu_ready), 32'(m_ready()));
            chk("m_WB_valid", 32'(bus.WB_valid), 32'(e_v));
            chk("m_WB_rf_en", 32'(bus.WB_rf_en), 32'(e_rf));
            chk("m_WB_data", bus.WB_data, e_d);
            chk("m_WB_rd", 32'(bus.WB_rd), 32'(e_rd));
            chk("m_WB_rob", 32'(bus.WB_rob_idx), 32'(e_rob));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fu_valid   = '0;
        bus.mispredict = 1'b0;
        bus.flush_mask = '0;
    endtask

    task automatic put(input int p, input logic [31:0] d,
                       input logic [6:0] rd, input logic [2:0] rob);
        bus.fu_valid[p]           = 1'b1;
        bus.fu_data[32*p +: 32]   = d;
        bus.fu_rd[7*p +: 7]       = rd;
        bus.fu_rob_idx[3*p +: 3]  = rob;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy [5];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idle();
        bus.fu_data    = '0;
        bus.fu_rd      = '0;
        bus.fu_rob_idx = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.fu_ready), 32'hF);
        chk("rst_valid", 32'(bus.WB_valid), 0);
        chk("rst_rf_en", 32'(bus.WB_rf_en), 0);
        chk("rst_data", bus.WB_data, 0);
        chk("rst_rd", 32'(bus.WB_rd), 0);
        chk("rst_rob", 32'(bus.WB_rob_idx), 0);

        // single result on port 2
        put(2, 32'hDEADBEEF, 7'd5, 3'd3);
        cyc();
        idle();
        cyc();
        chk("single_valid", 32'(bus.WB_valid), 1);
        chk("single_rd", 32'(bus.WB_rd), 5);
        chk("single_data", bus.WB_data, 32'hDEADBEEF);
        chk("single_rob", 32'(bus.WB_rob_idx), 3);
        chk("single_rf_en", 32'(bus.WB_rf_en), 1);
        cyc();
        chk("single_done", 32'(bus.WB_valid), 0);

        // all four ports at once from reset
        do_reset();
        for (int i = 0; i < 4; i++)
            put(i, 32'h1000 + i, 7'(10 + i), 3'(i));
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("cont_valid", 32'(bus.WB_valid), 1);
            chk("cont_rob", 32'(bus.WB_rob_idx), k);
        end
        cyc();
        chk("cont_end", 32'(bus.WB_valid), 0);

        // sustained contention: backpressure and rotation
        do_reset();
        for (int i = 0; i < 4; i++)
            put(i, 32'h2000 + i, 7'(20 + i), 3'(i));
        cyc();
        for (int i = 0; i < 4; i++)
            put(i, 32'h3000 + i, 7'(30 + i), 3'(4 + i));
        #1;
        chk("bp_ready0", 32'(bus.fu_ready), 32'(exp_rdy[0]));
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("bp_ready", 32'(bus.fu_ready), 32'(exp_rdy[k]));
            chk("bp_rob", 32'(bus.WB_rob_idx), k - 1);
        end
        idle();
        repeat (8) cyc();

        // port 0 back-to-back
        for (int k = 0; k < 6; k++) begin
            put(0, 32'(100 + k), 7'd1, 3'(k));
            if (k >= 2) begin
                chk("b2b_valid", 32'(bus.WB_valid), 1);
                chk("b2b_data", bus.WB_data, 32'(100 + k - 2));
            end
            #1;
            chk("b2b_ready", 32'(bus.fu_ready[0]), 1);
            cyc();
        end
        idle();
        chk("b2b_data4", bus.WB_data, 104);
        cyc();
        chk("b2b_data5", bus.WB_data, 105);
        cyc();
        chk("b2b_end", 32'(bus.WB_valid), 0);

        // flush of a buffered entry
        do_reset();
        put(0, 32'hAAAA0004, 7'd20, 3'd4);
        put(1, 32'hBBBB0005, 7'd21, 3'd5);
        cyc();
        idle();
        bus.mispredict = 1'b1;
        bus.flush_mask = 8'h10;
        cyc();
        idle();
        chk("flush_valid", 32'(bus.WB_valid), 1);
        chk("flush_rob", 32'(bus.WB_rob_idx), 5);
        chk("flush_data", bus.WB_data, 32'hBBBB0005);
        cyc();
        chk("flush_gone", 32'(bus.WB_valid), 0);
        cyc();
        chk("flush_gone2", 32'(bus.WB_valid), 0);

        // flush of an incoming result
        put(2, 32'hCCCC0006, 7'd22, 3'd6);
        bus.mispredict = 1'b1;
        bus.flush_mask = 8'h40;
        cyc();
        idle();
        cyc();
        chk("drop_in", 32'(bus.WB_valid), 0);
        cyc();
        chk("drop_in2", 32'(bus.WB_valid), 0);

        // rd = 0 writes back without a register write
        put(3, 32'hDDDD0007, 7'd0, 3'd7);
        cyc();
        idle();
        cyc();
        chk("rd0_valid", 32'(bus.WB_valid), 1);
        chk("rd0_rob", 32'(bus.WB_rob_idx), 7);
        chk("rd0_rf_en", 32'(bus.WB_rf_en), 0);

        // reset mid-operation discards buffered results
        for (int i = 0; i < 4; i++)
            put(i, 32'h5000 + i, 7'(40 + i), 3'(i));
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_mid", 32'(bus.WB_valid), 0);
            cyc();
        end

        // mixed traffic against the model
        for (int k = 0; k < 300; k++) begin
            bus.fu_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                bus.fu_data[32*i +: 32]  = $urandom;
                bus.fu_rd[7*i +: 7]      = 7'($urandom_range(0, 3));
                bus.fu_rob_idx[3*i +: 3] = 3'($urandom);
            end
            bus.mispredict = ($urandom_range(0, 7) == 0);
            bus.flush_mask = bus.mispredict ? 8'($urandom) : 8'h00;
            cyc();
        end
        idle();
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
